toggle_port_responder: RTL and testbench
========================================

Name: toggle_port_responder

Overview:
- Memory-side responder for the toggle-style request/acknowledge port used by the ROM download path. The download controller flips `port_req` once per byte written.
- The block captures each request into a small FIFO and replays it as a valid/ready command to a memory backend (SDRAM command arbiter).
- For writes it updates `port_ack` when the backend accepts the command. For reads it updates `port_ack` when read data returns.
- Sits between `data_io`'s upload controller and the SDRAM controller, so downloads never lose a toggle while the SDRAM is busy refreshing or serving video ports.

Parameters:
AW, 23, word address width of port_a / mem_a
DEPTH_LOG2, 2, log2 of request FIFO depth (default 4 entries)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
port_req  in  1  request toggle; every level change is one new request (synchronous to clk_sys)
port_ack  out  1  equals the port_req level of the last completed request
port_a  in  AW  word address, sampled at the toggle
port_ds  in  2  byte strobes {hi,lo}
port_we  in  1  1=write, 0=read
port_d  in  16  write data
port_q  out  16  read data of last completed read
mem_valid  out  1  command valid to backend
mem_ready  in  1  backend accepts command
mem_we  out  1  command write flag
mem_a  out  AW  command address
mem_ds  out  2  command byte strobes
mem_d  out  16  command write data
mem_rvalid  in  1  read data valid, one cycle, in order
mem_rdata  in  16  read data
busy  out  1  FIFO non-empty or FSM not IDLE
overflow  out  1  sticky: a request was dropped because the FIFO was full

Behaviour:
- Reset (async, immediate):
  - port_ack=0, port_q=0, mem_valid=0, mem_we=0, mem_a=0, mem_ds=0, mem_d=0, overflow=0, busy=0.
  - FIFO is emptied, FSM goes to IDLE, req_seen=0.
  - If port_req=1 at reset release, the first edge captures it as a request.
- Capture: on each edge where port_req != req_seen:
  - push {port_req, port_we, port_a, port_ds, port_d} and set req_seen<=port_req.
  - The same edge can both push and pop; FIFO occupancy stays constant in that case.
- FIFO full at capture:
  - the entry is dropped, overflow<=1 (sticky until reset), req_seen is still updated.
  - port_ack then stays unequal to port_req until a later accepted request completes.
- FSM states:
  - IDLE: FIFO non-empty -> ISSUE. Registered mem_valid=1; mem_* fields are loaded from the FIFO head.
  - ISSUE: mem_valid and all mem_* fields held stable until mem_ready.
    - mem_ready & write -> DONE (mem_valid<=0).
    - mem_ready & read -> WAIT_RD (mem_valid<=0).
  - WAIT_RD: mem_rvalid -> port_q<=mem_rdata, -> DONE. mem_rvalid seen in any other state is ignored.
  - DONE: pop the head, port_ack<=head tag, -> IDLE.
- Latency, empty FIFO, IDLE, mem_ready=1, request sampled at edge N:
  - mem_valid is high after edge N+1.
  - Accepted at edge N+2.
  - Write: port_ack updates at edge N+3.
  - Read: port_ack updates 1 edge after the DONE entry that follows mem_rvalid.
- Throughput: one command every 3 cycles (writes) with no backpressure.
- Order: strict FIFO order; one outstanding backend command at a time.
- busy is combinational from FIFO count and FSM state.

Optional Feature:
- Macro: TOGGLE_PORT_MERGE_EN.
- Defined:
  - A captured write merges into the FIFO tail entry, instead of pushing, when all of these hold:
    - the FIFO is non-empty;
    - the tail is a write;
    - the tail is not the head currently in ISSUE/WAIT_RD/DONE;
    - the word address matches.
  - On merge: tail ds |= new ds; data bytes selected by the new ds are replaced; tail tag is set to the new port_req level.
  - A merge never sets overflow, even when the FIFO is full.
- Undefined: every request occupies its own entry.

Test Plan:
1. Single write: after reset, mem_ready=1; toggle port_req 0->1 with a=0x000010, ds=01, d=0x00AB, we=1.
   - Expect mem_valid high for one cycle with the same fields.
   - Expect port_ack=1 three edges after capture; port_q unchanged at 0.
2. Read with latency: toggle with we=0, a=0x000020; backend asserts mem_rvalid 4 cycles after accept with rdata=0x1234.
   - Expect port_q=0x1234 and port_ack equal to port_req one edge after DONE.
3. Backpressure and fill: mem_ready=0; issue 5 write toggles at 1-cycle spacing.
   - Expect 4 entries queued and the 5th dropped, with overflow=1.
   - Release mem_ready: expect 4 commands in order, and port_ack equal to the 4th toggle level, not the 5th.
4. Hold stability: mem_ready low 10 cycles during ISSUE.
   - Expect mem_valid, mem_a, mem_ds and mem_d constant throughout; exactly one acceptance.
5. Reset mid-read: assert reset while in WAIT_RD.
   - Expect immediate mem_valid=0, busy=0, port_ack=0, port_q=0.
   - A late mem_rvalid after release is ignored.
6. Merge (TOGGLE_PORT_MERGE_EN, mem_ready=0 with head in ISSUE): queue a write a=0x40 ds=01 d=0x00CD, then a write a=0x40 ds=10 d=0xEF00.
   - Expect one queued entry with ds=11, d=0xEFCD.
   - Without the macro, expect two entries.

Source files
------------

// File: rtl/toggle_port_responder.sv
// toggle_port_responder
//
// Memory-side responder for the toggle-style request/acknowledge port on the
// ROM download path. Each level change of port_req is one request. The request
// is captured into a small FIFO and replayed as a valid/ready command to the
// memory backend, one outstanding command at a time and in strict FIFO order.
// port_ack follows the port_req level of the last completed request. A write
// completes when the backend accepts it. A read completes when its data returns.
//
// Ports:
//   clk_sys     system clock, rising edge
//   reset       asynchronous, active-high reset
//   port_req    request toggle (synchronous to clk_sys)
//   port_ack    port_req level of the last completed request
//   port_a      word address, sampled at the toggle
//   port_ds     byte strobes {hi,lo}
//   port_we     1=write, 0=read
//   port_d      write data
//   port_q      read data of the last completed read
//   mem_valid   command valid to backend
//   mem_ready   backend accepts command
//   mem_we      command write flag
//   mem_a       command address
//   mem_ds      command byte strobes
//   mem_d       command write data
//   mem_rvalid  read data valid (one cycle, in order)
//   mem_rdata   read data
//   busy        FIFO non-empty or FSM not idle
//   overflow    sticky: a request was dropped because the FIFO was full
//
// Build option:
//   TOGGLE_PORT_MERGE_EN  when defined, a captured write to the same word as a
//                         queued (not yet launched) tail write is merged into
//                         that tail entry instead of taking a new entry.

module toggle_port_responder #(
  parameter int AW         = 23,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          port_req,
  output logic          port_ack,
  input  logic [AW-1:0] port_a,
  input  logic [1:0]    port_ds,
  input  logic          port_we,
  input  logic [15:0]   port_d,
  output logic [15:0]   port_q,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [1:0]    mem_ds,
  output logic [15:0]   mem_d,
  input  logic          mem_rvalid,
  input  logic [15:0]   mem_rdata,
  output logic          busy,
  output logic          overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Request FIFO storage, one array per field.
  logic                  fifo_tag [DEPTH];
  logic                  fifo_we  [DEPTH];
  logic [AW-1:0]         fifo_a   [DEPTH];
  logic [1:0]            fifo_ds  [DEPTH];
  logic [15:0]           fifo_d   [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  req_seen;
  logic [1:0]            state;

  logic                  req_edge;
  logic                  full;
  logic                  merge;
  logic                  push;
  logic                  drop;
  logic                  pop;

  assign req_edge = (port_req != req_seen);
  assign full     = (count == FULL_CNT);
  assign pop      = (state == ST_DONE);

`ifdef TOGGLE_PORT_MERGE_EN
  logic [DEPTH_LOG2-1:0] tail_idx;
  assign tail_idx = wr_ptr - 1'b1;

  // The tail may only be merged when it is not the head. With a single entry
  // the head is either being launched this edge (IDLE), already on the bus,
  // or being retired, so requiring two or more entries keeps the launched
  // command and its completion tag consistent.
  assign merge = req_edge && port_we && (count > CNT_ONE) &&
                 fifo_we[tail_idx] && (fifo_a[tail_idx] == port_a);
`else
  assign merge = 1'b0;
`endif

  assign push = req_edge && !merge && !full;
  assign drop = req_edge && !merge && full;

  assign busy = (count != '0) || (state != ST_IDLE);

  // FIFO pointers, occupancy and capture tracking.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req_seen <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // req_seen follows every edge, including dropped ones, so a single
      // toggle is never counted twice.
      if (req_edge) req_seen <= port_req;
      if (drop)     overflow <= 1'b1;
      if (push)     wr_ptr   <= wr_ptr + 1'b1;
      if (pop)      rd_ptr   <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload; contents are don't-care while the entry is empty.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_tag[wr_ptr] <= port_req;
      fifo_we[wr_ptr]  <= port_we;
      fifo_a[wr_ptr]   <= port_a;
      fifo_ds[wr_ptr]  <= port_ds;
      fifo_d[wr_ptr]   <= port_d;
    end
`ifdef TOGGLE_PORT_MERGE_EN
    else if (merge) begin
      fifo_tag[tail_idx]       <= port_req;
      fifo_ds[tail_idx]        <= fifo_ds[tail_idx] | port_ds;
      if (port_ds[1]) fifo_d[tail_idx][15:8] <= port_d[15:8];
      if (port_ds[0]) fifo_d[tail_idx][7:0]  <= port_d[7:0];
    end
`endif
  end

  // Command FSM: launch head, hold until accepted, wait for read data, retire.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_ds    <= 2'b00;
      mem_d     <= 16'h0000;
      port_ack  <= 1'b0;
      port_q    <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            mem_valid <= 1'b1;
            mem_we    <= fifo_we[rd_ptr];
            mem_a     <= fifo_a[rd_ptr];
            mem_ds    <= fifo_ds[rd_ptr];
            mem_d     <= fifo_d[rd_ptr];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= mem_we ? ST_DONE : ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (mem_rvalid) begin
            port_q <= mem_rdata;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          port_ack <= fifo_tag[rd_ptr];
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_port_responder.sv
module tb_toggle_port_responder;

  localparam int AW = 23;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          port_req = 1'b0;
  logic          port_ack;
  logic [AW-1:0] port_a = '0;
  logic [1:0]    port_ds = 2'b00;
  logic          port_we = 1'b0;
  logic [15:0]   port_d = 16'h0000;
  logic [15:0]   port_q;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [1:0]    mem_ds;
  logic [15:0]   mem_d;
  logic          mem_rvalid = 1'b0;
  logic [15:0]   mem_rdata = 16'h0000;
  logic          busy;
  logic          overflow;

  toggle_port_responder #(.AW(AW), .DEPTH_LOG2(2)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .port_req   (port_req),
    .port_ack   (port_ack),
    .port_a     (port_a),
    .port_ds    (port_ds),
    .port_we    (port_we),
    .port_d     (port_d),
    .port_q     (port_q),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_ds     (mem_ds),
    .mem_d      (mem_d),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int passes = 0;
  int total = 0;
  int accept_cnt = 0;
  int base;
  logic [41:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [41:0] cmd(input logic we, input logic [AW-1:0] a,
                                      input logic [1:0] ds, input logic [15:0] d);
    return {we, a, ds, d};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Toggle port_req with the given fields; returns just after the capture edge.
  task automatic toggle(input logic we, input logic [AW-1:0] a, input logic [1:0] ds,
                        input logic [15:0] d, input bit push_exp);
    port_req = ~port_req;
    port_we  = we;
    port_a   = a;
    port_ds  = ds;
    port_d   = d;
    if (push_exp) exp_q.push_back(cmd(we, a, ds, d));
    tick();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  // Scoreboard monitor: every accepted command must match the queue head.
  always @(negedge clk_sys) begin
    if (!reset && mem_valid && mem_ready) begin
      accept_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_cmd: got 0x%0h expected none", {mem_we, mem_a, mem_ds, mem_d});
      end else begin
        chk("cmd_fields", {mem_we, mem_a, mem_ds, mem_d}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    mem_ready = 1'b1;
    repeat (2) tick();
    chk("reset_outputs", {port_ack, port_q, mem_valid, busy, overflow, mem_a, mem_ds, mem_d}, 0);
    reset = 1'b0;
    tick();
    chk("post_reset_idle", {port_ack, mem_valid, busy, overflow}, 0);

    // 1: single write, ack three edges after capture
    toggle(1'b1, 'h10, 2'b01, 16'h00AB, 1'b1);
    chk("t1_busy_after_capture", {busy, mem_valid}, 2'b10);
    tick();
    chk("t1_valid_n1", mem_valid, 1);
    tick();
    chk("t1_n2_valid_ack", {mem_valid, port_ack}, 2'b00);
    tick();
    chk("t1_ack_n3", port_ack, 1);
    chk("t1_port_q", port_q, 16'h0000);

    // 2: read, data returns 4 cycles after accept
    toggle(1'b0, 'h20, 2'b11, 16'h0000, 1'b1);
    tick();
    tick();
    chk("t2_accepted", mem_valid, 0);
    repeat (3) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1234;
    tick();
    mem_rvalid = 1'b0;
    chk("t2_port_q", port_q, 16'h1234);
    chk("t2_ack_not_yet", port_ack, 1);
    tick();
    chk("t2_ack_after_done", port_ack, 0);

    // 3: backpressure, fill FIFO, fifth request dropped
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      toggle(1'b1, AW'(32'h100 + i), 2'b11, 16'hA000 + 16'(i), i < 4);
      if (i == 3) chk("t3_no_overflow_yet", overflow, 0);
    end
    chk("t3_overflow", overflow, 1);
    chk("t3_head_issued", {busy, mem_valid, port_ack}, 3'b110);
    base = accept_cnt;
    mem_ready = 1'b1;
    wait_idle(60, "t3_drain");
    chk("t3_accepts", accept_cnt - base, 4);
    chk("t3_ack_is_4th", {port_req, port_ack}, 2'b10);
    chk("t3_overflow_sticky", overflow, 1);

    // 4: hold stability under 10 cycles of backpressure
    mem_ready = 1'b0;
    toggle(1'b1, 'h55, 2'b10, 16'h5A00, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold", {mem_valid, mem_we, mem_a, mem_ds, mem_d},
          {1'b1, cmd(1'b1, 'h55, 2'b10, 16'h5A00)});
      tick();
    end
    base = accept_cnt;
    mem_ready = 1'b1;
    wait_idle(20, "t4_drain");
    chk("t4_one_accept", accept_cnt - base, 1);
    chk("t4_ack", port_ack, 0);

    // 5: reset while waiting for read data
    toggle(1'b0, 'h77, 2'b11, 16'h0000, 1'b1);
    tick();
    tick();
    tick();
    reset    = 1'b1;
    port_req = 1'b0;
    #1;
    chk("t5_async_reset", {mem_valid, busy, port_ack, port_q, overflow}, 0);
    tick();
    reset = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("t5_late_rvalid_ignored", {port_q, busy, port_ack}, 0);

    // Reset released with port_req high: first edge is a request
    reset    = 1'b1;
    port_req = 1'b1;
    port_we  = 1'b1;
    port_a   = 'h99;
    port_ds  = 2'b01;
    port_d   = 16'h0042;
    exp_q.push_back(cmd(1'b1, 'h99, 2'b01, 16'h0042));
    tick();
    reset = 1'b0;
    tick();
    chk("t7_capture_at_release", busy, 1);
    wait_idle(20, "t7_drain");
    chk("t7_ack", port_ack, 1);

    // 6: merge into queued tail while head is held in ISSUE
    mem_ready = 1'b0;
    toggle(1'b1, 'h30, 2'b11, 16'h1111, 1'b1);
    tick();
    toggle(1'b1, 'h40, 2'b01, 16'h00CD, 1'b0);
    toggle(1'b1, 'h40, 2'b10, 16'hEF00, 1'b0);
`ifdef TOGGLE_PORT_MERGE_EN
    exp_q.push_back(cmd(1'b1, 'h40, 2'b11, 16'hEFCD));
`else
    exp_q.push_back(cmd(1'b1, 'h40, 2'b01, 16'h00CD));
    exp_q.push_back(cmd(1'b1, 'h40, 2'b10, 16'hEF00));
`endif
    base = accept_cnt;
    mem_ready = 1'b1;
    wait_idle(30, "t6_drain");
`ifdef TOGGLE_PORT_MERGE_EN
    chk("t6_accepts", accept_cnt - base, 2);
`else
    chk("t6_accepts", accept_cnt - base, 3);
`endif
    chk("t6_ack", port_ack, 0);
    chk("t6_no_overflow", overflow, 0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
